// File: rtl/div_pkg.sv
// Shared types and flag helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int N = 32
) (
  input  logic [N-1:0] rem_i,
  input  logic         qmsb_i,
  input  logic [N-1:0] divisor_i,
  output logic [N-1:0] next_rem_o,
  output logic         q_bit_o
);

  logic [N:0] shifted;
  logic [N:0] diff;

  always_comb begin
    shifted    = {rem_i, qmsb_i};
    diff       = shifted - {1'b0, divisor_i};
    // A borrow out of the top bit means the divisor did not fit: restore.
    q_bit_o    = ~diff[N];
    next_rem_o = diff[N] ? shifted[N-1:0] : diff[N-1:0];
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle unsigned divider controller: accepts a request, iterates div_step
// N times and presents quotient/remainder/flags over a valid/ready handshake.
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter  int N  = 32,
  localparam int CW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic [3:0]   flags
);

  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  div_state_t    state_q, state_d;
  logic [N-1:0]  rem_q, rem_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  quot_q, quot_d;
  logic [N-1:0]  remd_q, remd_d;
  logic [3:0]    flags_q, flags_d;

  logic [N-1:0]  step_rem;
  logic          step_bit;
  logic [N-1:0]  step_q;

  div_step #(.N(N)) u_step (
    .rem_i      (rem_q),
    .qmsb_i     (q_q[N-1]),
    .divisor_i  (dvs_q),
    .next_rem_o (step_rem),
    .q_bit_o    (step_bit)
  );

  assign step_q = {q_q[N-2:0], step_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      remd_q  <= '0;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      remd_q  <= remd_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    q_d         = q_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    quot_d      = quot_q;
    remd_d      = remd_q;
    flags_d     = flags_q;
    start_ready = (state_q == IDLE);
    res_valid   = (state_q == DONE);

    // Abort wins over accept and completion; visible outputs keep their last values.
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            rem_d = '0;
            q_d   = dividend;
            dvs_d = divisor;
            cnt_d = CNT_LAST;
            if (divisor == '0) begin
              state_d = DONE;
              quot_d  = '1;
              remd_d  = dividend;
              flags_d = pack_flags(1'b1, 1'b0, 1'b0, 1'b1);
            end else begin
              state_d = CALC;
            end
          end
        end
        CALC: begin
          rem_d = step_rem;
          q_d   = step_q;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d = DONE;
            quot_d  = step_q;
            remd_d  = step_rem;
            flags_d = pack_flags(step_q[N-1], step_q == '0, step_rem != '0, 1'b0);
          end
        end
        DONE: begin
          if (res_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign quotient  = quot_q;
  assign remainder = remd_q;
  assign flags     = flags_q;

endmodule
